// File: rtl/hls2x4_mac_sched.sv
// hls2x4_mac_sched
// Computes y = A * x for a ROWS x COLS signed matrix by time-sharing one external
// multiplier that returns the truncated DATA_WIDTH-bit product combinationally.
// One multiply per cycle in row-major order, accumulating per row; y_flat is
// registered and announced with a one-cycle ap_done/ap_ready pulse.
//
// Ports:
//   ap_clk, ap_rst       rising-edge clock, synchronous active-high reset
//   ap_start             start request, sampled only while idle
//   ap_done, ap_ready    one-cycle pulse when y_flat becomes valid
//   ap_idle              high while waiting for ap_start
//   a_flat               A[r][c] at [(r*COLS+c)*DATA_WIDTH +: DATA_WIDTH]
//   x_flat               x[c] at [c*DATA_WIDTH +: DATA_WIDTH]
//   mul_a, mul_b         registered operands for the shared multiplier
//   mul_p                low DATA_WIDTH bits of mul_a * mul_b (combinational)
//   y_flat               y[r] at [r*DATA_WIDTH +: DATA_WIDTH]
module hls2x4_mac_sched #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ROWS       = 2,
    parameter int unsigned COLS       = 4
) (
    input  logic                            ap_clk,
    input  logic                            ap_rst,
    input  logic                            ap_start,
    output logic                            ap_done,
    output logic                            ap_idle,
    output logic                            ap_ready,
    input  logic [ROWS*COLS*DATA_WIDTH-1:0] a_flat,
    input  logic [COLS*DATA_WIDTH-1:0]      x_flat,
    output logic [DATA_WIDTH-1:0]           mul_a,
    output logic [DATA_WIDTH-1:0]           mul_b,
    input  logic [DATA_WIDTH-1:0]           mul_p,
    output logic [ROWS*DATA_WIDTH-1:0]      y_flat
);

    localparam int unsigned NumMac = ROWS * COLS;
    // Wide enough to hold NumMac itself, so idx+1 never wraps.
    localparam int unsigned IdxW   = $clog2(NumMac + 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e                          r_state;
    state_e                          w_state_next;
    logic [IdxW-1:0]                 r_idx;
    logic [ROWS*COLS*DATA_WIDTH-1:0] r_a_lat;
    logic [COLS*DATA_WIDTH-1:0]      r_x_lat;
    logic [DATA_WIDTH-1:0]           r_acc [ROWS];
    logic [DATA_WIDTH-1:0]           r_mul_a;
    logic [DATA_WIDTH-1:0]           r_mul_b;
    logic [ROWS*DATA_WIDTH-1:0]      r_y;

    logic [IdxW-1:0]                 w_idx_next;
    logic [IdxW-1:0]                 w_row;
    logic [IdxW-1:0]                 w_col_next;
    logic                            w_last;
    logic [DATA_WIDTH-1:0]           w_pair_a;
    logic [DATA_WIDTH-1:0]           w_pair_b;

    assign w_idx_next = r_idx + IdxW'(1);
    assign w_row      = r_idx / IdxW'(COLS);
    assign w_col_next = w_idx_next % IdxW'(COLS);
    assign w_last     = (r_idx == IdxW'(NumMac - 1));

    // Operand pair for the next index; zero once the last pair has been issued.
    always_comb begin
        w_pair_a = '0;
        w_pair_b = '0;
        if (!w_last) begin
            for (int k = 0; k < NumMac; k++) begin
                if (w_idx_next == IdxW'(k)) begin
                    w_pair_a = r_a_lat[k*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            for (int c = 0; c < COLS; c++) begin
                if (w_col_next == IdxW'(c)) begin
                    w_pair_b = r_x_lat[c*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:  if (ap_start) w_state_next = StRun;
            StRun:   if (w_last) w_state_next = StDone;
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_idx   <= '0;
            r_a_lat <= '0;
            r_x_lat <= '0;
            r_mul_a <= '0;
            r_mul_b <= '0;
            r_y     <= '0;
            for (int r = 0; r < ROWS; r++) begin
                r_acc[r] <= '0;
            end
        end else begin
            case (r_state)
                StIdle: begin
                    if (ap_start) begin
                        r_a_lat <= a_flat;
                        r_x_lat <= x_flat;
                        r_mul_a <= a_flat[DATA_WIDTH-1:0];
                        r_mul_b <= x_flat[DATA_WIDTH-1:0];
                        r_idx   <= '0;
                        for (int r = 0; r < ROWS; r++) begin
                            r_acc[r] <= '0;
                        end
                    end else begin
                        r_mul_a <= '0;
                        r_mul_b <= '0;
                    end
                end
                StRun: begin
                    for (int r = 0; r < ROWS; r++) begin
                        if (w_row == IdxW'(r)) begin
                            r_acc[r] <= r_acc[r] + mul_p;
                        end
                    end
                    r_mul_a <= w_pair_a;
                    r_mul_b <= w_pair_b;
                    r_idx   <= w_idx_next;
                    // Final product is folded in here rather than costing a cycle.
                    if (w_last) begin
                        for (int r = 0; r < ROWS; r++) begin
                            r_y[r*DATA_WIDTH +: DATA_WIDTH] <=
                                r_acc[r] + ((w_row == IdxW'(r)) ? mul_p : '0);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign ap_idle  = (r_state == StIdle);
    assign ap_done  = (r_state == StDone);
    assign ap_ready = (r_state == StDone);
    assign mul_a    = r_mul_a;
    assign mul_b    = r_mul_b;
    assign y_flat   = r_y;

endmodule

// File: tb/tb_hls2x4_mac_sched.sv
module tb_hls2x4_mac_sched;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         done, idle, ready;
    logic [127:0] a_flat;
    logic [63:0]  x_flat;
    logic [15:0]  mul_a, mul_b, mul_p;
    logic [31:0]  y_flat;
    logic [31:0]  prod;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Shared multiplier: low 16 bits of the signed product.
    assign prod  = $signed(mul_a) * $signed(mul_b);
    assign mul_p = prod[15:0];

    hls2x4_mac_sched dut (
        .ap_clk   (clk),
        .ap_rst   (rst),
        .ap_start (start),
        .ap_done  (done),
        .ap_idle  (idle),
        .ap_ready (ready),
        .a_flat   (a_flat),
        .x_flat   (x_flat),
        .mul_a    (mul_a),
        .mul_b    (mul_b),
        .mul_p    (mul_p),
        .y_flat   (y_flat)
    );

    typedef struct {
        string        name;
        logic [127:0] a;
        logic [63:0]  x;
        logic [15:0]  y0;
        logic [15:0]  y1;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] mk4(input int e0, input int e1, input int e2, input int e3);
        logic [15:0] v0, v1, v2, v3;
        v0 = 16'(e0); v1 = 16'(e1); v2 = 16'(e2); v3 = 16'(e3);
        return {v3, v2, v1, v0};
    endfunction

    // Reference: plain dot products with truncated products and wrapping sums.
    function automatic logic [31:0] model_y(input logic [127:0] a, input logic [63:0] x);
        logic [15:0] y [2];
        logic signed [15:0] av, xv;
        logic [31:0] p;
        for (int r = 0; r < 2; r++) begin
            y[r] = 16'd0;
            for (int c = 0; c < 4; c++) begin
                av = a[(r*4+c)*16 +: 16];
                xv = x[c*16 +: 16];
                p = av * xv;
                y[r] = y[r] + p[15:0];
            end
        end
        return {y[1], y[0]};
    endfunction

    // Full transaction with the cycle-exact operand sequence and done timing.
    task automatic run_check(input string name, input logic [127:0] a, input logic [63:0] x,
                             input logic [31:0] exp_y);
        logic [31:0] pair_ok;
        @(negedge clk);
        a_flat = a; x_flat = x; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        pair_ok = 32'd0;
        for (int k = 0; k < 8; k++) begin
            if (mul_a === a[k*16 +: 16] && mul_b === x[(k%4)*16 +: 16] && !idle && !done)
                pair_ok[k] = 1'b1;
            @(negedge clk);
        end
        check({name, " mul seq"}, 64'(pair_ok), 64'hFF);
        check({name, " done/ready"}, {62'd0, done, ready}, 64'd3);
        check({name, " y"}, 64'(y_flat), 64'(exp_y));
        @(negedge clk);
        check({name, " idle after"}, {62'd0, idle, done}, 64'd2);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [127:0] a1, ar;
        logic [63:0]  x1, xr;
        int dones, bad_done_cyc, idle_low, ybad;

        a1 = {mk4(5, 6, 7, 8), mk4(1, 2, 3, 4)};
        x1 = mk4(1, 2, 3, 4);
        vecs[0] = '{"basic",  a1, x1, 16'd30, 16'd70};
        vecs[1] = '{"signed", {64'd0, mk4(-3, 'h7FFF, 0, 0)}, mk4(5, 2, 0, 0), 16'hFFEF, 16'd0};
        vecs[2] = '{"trunc",  {8{16'h0100}}, {4{16'h0100}}, 16'd0, 16'd0};
        vecs[3] = '{"ones",   {mk4(2, 2, 2, 2), mk4(1, 1, 1, 1)}, mk4(1, 1, 1, 1), 16'd4, 16'd8};
        vecs[4] = '{"x_one",  a1, mk4(1, 1, 1, 1), 16'd10, 16'd26};

        rst = 1'b1; start = 1'b0; a_flat = '0; x_flat = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("reset values",
                  {done, ready, idle, mul_a, mul_b, y_flat[12:0]},
                  {1'b0, 1'b0, 1'b1, 16'd0, 16'd0, 13'd0});
            check("reset y", 64'(y_flat), 64'd0);
        end

        for (int i = 0; i < 5; i++)
            run_check(vecs[i].name, vecs[i].a, vecs[i].x, {vecs[i].y1, vecs[i].y0});

        for (int i = 0; i < 20; i++) begin
            ar = {$urandom, $urandom, $urandom, $urandom};
            xr = {$urandom, $urandom};
            if (i < 5) begin
                ar = ar & {8{16'h800F}};
                xr = xr & {4{16'h800F}};
            end
            run_check("random", ar, xr, model_y(ar, xr));
        end

        // ap_start held for 30 cycles: dones expected in cycles 9, 19, 29.
        @(negedge clk);
        a_flat = vecs[3].a; x_flat = vecs[3].x; start = 1'b1;
        dones = 0; bad_done_cyc = 0; idle_low = 0; ybad = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (!idle) idle_low++;
            if (done) begin
                dones++;
                if (i % 10 != 9) bad_done_cyc++;
                if (y_flat !== {16'd8, 16'd4}) ybad++;
            end
            if (i == 29) start = 1'b0;
        end
        check("held start dones", 64'(dones), 64'd3);
        check("held start done timing", 64'(bad_done_cyc), 64'd0);
        check("held start y", 64'(ybad), 64'd0);
        check("held start idle low", 64'(idle_low), 64'd27);

        // Operand change plus start pulse at RUN cycle 3.
        @(negedge clk);
        a_flat = a1; x_flat = x1; start = 1'b1;
        dones = 0; bad_done_cyc = 0;
        for (int i = 1; i <= 22; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            if (i == 3) begin
                a_flat = {8{16'h1234}}; x_flat = {4{16'h0777}}; start = 1'b1;
            end
            if (i == 4) start = 1'b0;
            if (i == 9) check("mid-run change y", 64'(y_flat), 64'({16'd70, 16'd30}));
            if (done) begin
                dones++;
                if (i != 9) bad_done_cyc++;
            end
        end
        check("mid-run change dones", 64'(dones), 64'd1);
        check("mid-run change timing", 64'(bad_done_cyc), 64'd0);

        // Reset during RUN cycle 5 (y_flat still holds 30/70 from before).
        @(negedge clk);
        a_flat = a1; x_flat = mk4(1, 1, 1, 1); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort state", {done, ready, idle, mul_a, mul_b, 13'd0},
              {1'b0, 1'b0, 1'b1, 16'd0, 16'd0, 13'd0});
        check("abort y", 64'(y_flat), 64'd0);
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || !idle) dones++;
        end
        check("abort no done", 64'(dones), 64'd0);
        run_check("after abort", a1, mk4(1, 1, 1, 1), {16'd26, 16'd10});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
